// File: rtl/paged_ram_loader_pkg.sv
// Shared definitions for the paged RAM and its nibble-serial program loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package paged_ram_loader_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int ADDR_W_DEF  = 4;
  localparam int BANK_AW_DEF = 3;

  // Loader FSM states
  typedef enum logic [1:0] {
    LD_IDLE    = 2'd0,
    LD_COLLECT = 2'd1,
    LD_WRITE   = 2'd2
  } ld_state_t;

  // Number of nibbles that make up one data word
  function automatic int nib_count(input int dw);
    return dw / 4;
  endfunction

endpackage

// File: rtl/paged_ram_loader_ram8.sv
// Behavioural single-port RAM bank with registered read data.
// Latency: 1 cycle from EN0 (read) to Do0; writes land on the enabled edge.
// Backpressure: none; Do0 holds its value when the bank is idle or written.
module paged_ram_loader_ram8 #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          CLK,
  input  logic          EN0,
  input  logic          WE0,
  input  logic [AW-1:0] A0,
  input  logic [DW-1:0] Di0,
  output logic [DW-1:0] Do0
);

  logic [DW-1:0] mem [2**AW];

  // Write or read the addressed word when the bank is enabled
  always_ff @(posedge CLK) begin
    if (EN0) begin
      if (WE0) mem[A0] <= Di0;
      else     Do0     <= mem[A0];
    end
  end

endmodule

// File: rtl/paged_ram_loader.sv
// Banked single-port data RAM with a nibble-serial loader that owns the port while LD_MODE is high.
// Latency: CPU read data on DOUT 1 cycle after the address; loader writes 1 cycle after the last nibble.
// Backpressure: none; CPU RI/reads are ignored and DOUT holds while the loader owns the RAM.
module paged_ram_loader
  import paged_ram_loader_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int BANK_AW = BANK_AW_DEF
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] DIN,
  input  logic              RI,
  output logic [DATA_W-1:0] DOUT,
  input  logic              LD_MODE,
  input  logic              LD_STB,
  input  logic [3:0]        LD_NIB,
  output logic [ADDR_W-1:0] LD_PTR,
  output logic              LD_WRAP
);

  localparam int NUM_BANKS = 2**(ADDR_W - BANK_AW);
  localparam int SEL_W     = ADDR_W - BANK_AW;
  localparam int NIBS      = nib_count(DATA_W);
  localparam int CNT_W     = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(NIBS - 1);
  localparam logic [ADDR_W-1:0] PTR_MAX  = '1;

  ld_state_t         state, state_nxt;
  logic              ld_mode_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] asm_q, wdat_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              wrap_q;
  logic              ld_start, ld_shift, ld_done, ld_write;

  logic              own, cpu_rd;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_a;
  logic [DATA_W-1:0] ram_di;

  logic              rd_q;
  logic [SEL_W-1:0]  sel_q;
  logic [DATA_W-1:0] dout_hold_q;
  logic [DATA_W-1:0] bank_do [NUM_BANKS];

  // Loader state register
  always_ff @(posedge CLK) begin
    if (!RESETn) state <= LD_IDLE;
    else         state <= state_nxt;
  end

  // Loader next-state and datapath control
  always_comb begin
    state_nxt = state;
    ld_start  = 1'b0;
    ld_shift  = 1'b0;
    ld_done   = 1'b0;
    ld_write  = 1'b0;
    case (state)
      LD_IDLE: begin
        if (LD_MODE && !ld_mode_q) begin
          state_nxt = LD_COLLECT;
          ld_start  = 1'b1;
        end
      end
      LD_COLLECT: begin
        if (!LD_MODE) begin
          state_nxt = LD_IDLE;
        end else if (LD_STB) begin
          ld_shift = 1'b1;
          if (cnt_q == CNT_LAST) begin
            ld_done   = 1'b1;
            state_nxt = LD_WRITE;
          end
        end
      end
      LD_WRITE: begin
        // A strobe landing here starts the next word so no nibble is lost
        ld_write  = 1'b1;
        ld_shift  = LD_STB;
        state_nxt = LD_MODE ? LD_COLLECT : LD_IDLE;
      end
      default: state_nxt = LD_IDLE;
    endcase
  end

  // Loader datapath: nibble assembly, write-data capture, pointer and wrap flag
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      ld_mode_q <= 1'b0;
      cnt_q     <= '0;
      asm_q     <= '0;
      wdat_q    <= '0;
      ptr_q     <= '0;
      wrap_q    <= 1'b0;
    end else begin
      ld_mode_q <= LD_MODE;
      wrap_q    <= ld_write && (ptr_q == PTR_MAX);
      if (ld_start) begin
        ptr_q <= '0;
        cnt_q <= '0;
      end
      if (ld_shift) begin
        asm_q <= {asm_q[DATA_W-5:0], LD_NIB};
        cnt_q <= ld_done ? '0 : cnt_q + 1'b1;
      end
      if (ld_done)  wdat_q <= {asm_q[DATA_W-5:0], LD_NIB};
      if (ld_write) ptr_q  <= ptr_q + 1'b1;
    end
  end

  // Port arbitration: the loader owns the RAM while active or LD_MODE is high
  always_comb begin
    own    = (state != LD_IDLE) || LD_MODE;
    ram_en = RESETn && (own ? (state == LD_WRITE) : 1'b1);
    ram_we = own ? 1'b1   : RI;
    ram_a  = own ? ptr_q  : ADDR;
    ram_di = own ? wdat_q : DIN;
    cpu_rd = RESETn && !own && !RI;
  end

  // Bank select is registered alongside the read so the output mux tracks it
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      rd_q        <= 1'b0;
      sel_q       <= '0;
      dout_hold_q <= '0;
    end else begin
      rd_q        <= cpu_rd;
      dout_hold_q <= DOUT;
      if (cpu_rd) sel_q <= ADDR[ADDR_W-1:BANK_AW];
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic bank_en;
    assign bank_en = ram_en && (ram_a[ADDR_W-1:BANK_AW] == SEL_W'(b));
    paged_ram_loader_ram8 #(.DW(DATA_W), .AW(BANK_AW)) u_ram (
      .CLK (CLK),
      .EN0 (bank_en),
      .WE0 (ram_we),
      .A0  (ram_a[BANK_AW-1:0]),
      .Di0 (ram_di),
      .Do0 (bank_do[b])
    );
  end

  assign DOUT    = rd_q ? bank_do[sel_q] : dout_hold_q;
  assign LD_PTR  = ptr_q;
  assign LD_WRAP = wrap_q;

endmodule

// File: tb/tb_paged_ram_loader.sv
// Directed and randomized bench for paged_ram_loader against a word-level memory model.
// Latency: checks read data one cycle after the address and loader writes after the last nibble.
// Backpressure: checks that CPU accesses are ignored and DOUT holds while the loader owns the RAM.
module tb_paged_ram_loader;

  logic       CLK;
  logic       RESETn;
  logic [3:0] ADDR;
  logic [7:0] DIN;
  logic       RI;
  logic [7:0] DOUT;
  logic       LD_MODE;
  logic       LD_STB;
  logic [3:0] LD_NIB;
  logic [3:0] LD_PTR;
  logic       LD_WRAP;

  paged_ram_loader dut (
    .CLK     (CLK),
    .RESETn  (RESETn),
    .ADDR    (ADDR),
    .DIN     (DIN),
    .RI      (RI),
    .DOUT    (DOUT),
    .LD_MODE (LD_MODE),
    .LD_STB  (LD_STB),
    .LD_NIB  (LD_NIB),
    .LD_PTR  (LD_PTR),
    .LD_WRAP (LD_WRAP)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: memory image, loader pointer, wrap bookkeeping
  logic [7:0] m_mem [16];
  int         m_ptr;
  int         exp_wraps;
  int         wrap_seen;
  int         n_cmp;
  int         n_err;
  logic [7:0] dout_before;
  logic [7:0] w;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    if (LD_WRAP === 1'b1) wrap_seen++;
  endtask

  task automatic ld_nib(input logic [3:0] n);
    LD_STB = 1'b1;
    LD_NIB = n;
    tick();
    LD_STB = 1'b0;
  endtask

  // One word, MS nibble first; fast leaves no idle cycle so the next strobe lands in the write cycle
  task automatic ld_word(input logic [7:0] wd, input bit fast);
    ld_nib(wd[7:4]);
    repeat ($urandom_range(0, 2)) tick();
    ld_nib(wd[3:0]);
    m_mem[m_ptr] = wd;
    if (m_ptr == 15) exp_wraps++;
    m_ptr = (m_ptr + 1) % 16;
    if (!fast) tick();
  endtask

  task automatic cpu_write(input int a, input logic [7:0] d);
    ADDR = 4'(a);
    DIN  = d;
    RI   = 1'b1;
    tick();
    RI   = 1'b0;
    m_mem[a] = d;
  endtask

  task automatic cpu_read(input int a, input string tag);
    ADDR = 4'(a);
    RI   = 1'b0;
    tick();
    chk(tag, 32'(DOUT), 32'(m_mem[a]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_err = 0; wrap_seen = 0; exp_wraps = 0; m_ptr = 0;
    RESETn = 1'b0; ADDR = '0; DIN = '0; RI = 1'b0;
    LD_MODE = 1'b0; LD_STB = 1'b0; LD_NIB = '0;

    // 1: reset values, CPU writes with no write-through, back-to-back cross-bank reads
    tick(); tick();
    chk("rst_dout", 32'(DOUT), 32'h0);
    chk("rst_ptr", 32'(LD_PTR), 32'h0);
    chk("rst_wrap", 32'(LD_WRAP), 32'h0);
    RESETn = 1'b1;
    ADDR = 4'd3; DIN = 8'hA5; RI = 1'b1;
    tick();
    chk("no_wthru_3", 32'(DOUT), 32'h0);
    ADDR = 4'd11; DIN = 8'h5A;
    tick();
    chk("no_wthru_11", 32'(DOUT), 32'h0);
    m_mem[3] = 8'hA5; m_mem[11] = 8'h5A;
    RI = 1'b0;
    cpu_read(3, "rd_3");
    chk("rd_3_val", 32'(DOUT), 32'hA5);
    cpu_read(11, "rd_11");
    chk("rd_11_val", 32'(DOUT), 32'h5A);

    // 2: load nibbles 1,2,3,4 then read back via the CPU
    LD_MODE = 1'b1; tick(); m_ptr = 0;
    dout_before = DOUT;
    ld_word(8'h12, 1'b0);
    ld_word(8'h34, 1'b0);
    chk("t2_ptr", 32'(LD_PTR), 32'd2);
    chk("t2_dout_hold", 32'(DOUT), 32'(dout_before));
    LD_MODE = 1'b0; tick();
    cpu_read(0, "t2_rd0");
    chk("t2_rd0_val", 32'(DOUT), 32'h12);
    cpu_read(1, "t2_rd1");
    chk("t2_rd1_val", 32'(DOUT), 32'h34);

    // 3: 16 random words wrap the pointer once; a 17th overwrites address 0
    LD_MODE = 1'b1; tick(); m_ptr = 0;
    wrap_seen = 0; exp_wraps = 0;
    dout_before = DOUT;
    for (int i = 0; i < 16; i++) begin
      w = 8'($urandom);
      ld_word(w, 1'b0);
      if (i == 14) chk("t3_no_early_wrap", 32'(wrap_seen), 32'd0);
    end
    chk("t3_wrap_pulse", 32'(LD_WRAP), 32'h1);
    chk("t3_ptr_wrapped", 32'(LD_PTR), 32'd0);
    w = 8'($urandom);
    ld_word(w, 1'b0);
    tick();
    chk("t3_wrap_count", 32'(wrap_seen), 32'(exp_wraps));
    chk("t3_wrap_once", 32'(wrap_seen), 32'd1);
    chk("t3_ptr_after17", 32'(LD_PTR), 32'(m_ptr));
    chk("t3_dout_hold", 32'(DOUT), 32'(dout_before));
    LD_MODE = 1'b0; tick();
    for (int a = 0; a < 16; a++) cpu_read(a, $sformatf("t3_rd%0d", a));

    // 4: a partial word is discarded; re-raising LD_MODE restarts pointer and nibble count
    LD_MODE = 1'b1; tick(); m_ptr = 0;
    w = 8'($urandom);
    ld_word(w, 1'b0);
    ld_nib(4'($urandom));
    LD_MODE = 1'b0; tick();
    chk("t4_ptr_kept", 32'(LD_PTR), 32'(m_ptr));
    tick();
    chk("t4_ptr_idle_hold", 32'(LD_PTR), 32'(m_ptr));
    cpu_read(1, "t4_rd1_untouched");
    LD_MODE = 1'b1; tick(); m_ptr = 0;
    chk("t4_ptr_restart", 32'(LD_PTR), 32'd0);
    w = 8'($urandom);
    ld_word(w, 1'b0);
    LD_MODE = 1'b0; tick();
    cpu_read(0, "t4_rd0_fresh");

    // 6: CPU write ignored during load; strobe in the write cycle is kept
    LD_MODE = 1'b1; tick(); m_ptr = 0;
    dout_before = DOUT;
    ADDR = 4'd5; DIN = 8'hFF; RI = 1'b1;
    w = 8'($urandom);
    ld_word(w, 1'b1);
    w = 8'($urandom);
    ld_word(w, 1'b0);
    chk("t6_ptr", 32'(LD_PTR), 32'd2);
    chk("t6_dout_hold", 32'(DOUT), 32'(dout_before));
    RI = 1'b0;
    LD_MODE = 1'b0; tick();
    cpu_read(0, "t6_rd0");
    cpu_read(1, "t6_rd1_wr_cycle_nib");
    cpu_read(5, "t6_rd5_ri_ignored");

    // 5: reset mid-collect drops the pending nibble, RAM contents survive
    LD_MODE = 1'b1; tick(); m_ptr = 0;
    w = 8'($urandom);
    ld_word(w, 1'b0);
    ld_nib(4'h9);
    RESETn = 1'b0; LD_MODE = 1'b0;
    tick();
    chk("t5_ptr", 32'(LD_PTR), 32'd0);
    chk("t5_wrap", 32'(LD_WRAP), 32'h0);
    chk("t5_dout", 32'(DOUT), 32'h0);
    RESETn = 1'b1; m_ptr = 0;
    for (int a = 0; a < 16; a++) cpu_read(a, $sformatf("t5_rd%0d", a));
    LD_MODE = 1'b1; tick();
    w = 8'($urandom);
    ld_word(w, 1'b0);
    LD_MODE = 1'b0; tick();
    cpu_read(0, "t5_rd0_after_reload");

    // Random CPU traffic against the model
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) cpu_write(int'($urandom_range(0, 15)), 8'($urandom));
      else                           cpu_read(int'($urandom_range(0, 15)), $sformatf("rnd_rd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
